// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Optional misalignment reporting is enabled with `define LSU_MISALIGN_EXC_EN.
module lsu_mem_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic              resp_store,
  output logic [DATA_W-1:0] rd
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic              misaligned
`endif
);

  // state  | meaning
  // IDLE   | ready for a new request
  // ACCESS | address (and store strobe) presented for one cycle
  // WAIT   | load latency count, address held
  // DONE   | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic              load_q, load_nxt;
  logic [2:0]        f3_q, f3_nxt;
  logic [1:0]        lo_q, lo_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, rd_nxt;
  logic [3:0]        mem_wr_nxt, strobe;
  logic [DATA_W-1:0] repl;
  logic              resp_valid_nxt, resp_store_nxt, req_ready_nxt, start;
  logic [1:0]        size_in;

  // 0 = byte, 1 = half, 2 = word; loads and stores decode funct3 differently
  function automatic logic [1:0] acc_size(input logic load, input logic [2:0] f3);
    if (load)
      return (f3[1:0] == 2'b00) ? 2'd0 : (f3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    return (f3 == 3'b000) ? 2'd0 : (f3 == 3'b001) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  assign start   = req_valid && (mem_read || mem_write);
  assign size_in = acc_size(mem_read, funct3);

  always_comb begin
    strobe = 4'b1111;
    repl   = wd;
    case (size_in)
      2'd0: begin
        strobe = 4'b0001 << addr[1:0];
        repl   = {4{wd[7:0]}};
      end
      2'd1: begin
        strobe = addr[1] ? 4'b1100 : 4'b0011;
        repl   = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic mis_req, misaligned_nxt;
  assign mis_req = ((size_in == 2'd1) && addr[0]) || ((size_in == 2'd2) && (addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_nxt      = state;
    load_nxt       = load_q;
    f3_nxt         = f3_q;
    lo_nxt         = lo_q;
    cnt_nxt        = cnt;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_wr_nxt     = 4'b0000;
    resp_valid_nxt = 1'b0;
    resp_store_nxt = 1'b0;
    rd_nxt         = rd;
`ifdef LSU_MISALIGN_EXC_EN
    misaligned_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load_nxt = mem_read;
          f3_nxt   = funct3;
          lo_nxt   = addr[1:0];
`ifdef LSU_MISALIGN_EXC_EN
          if (mis_req) begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
            resp_store_nxt = !mem_read;
            rd_nxt         = '0;
            misaligned_nxt = 1'b1;
          end else begin
`else
          begin
`endif
            state_nxt    = ACCESS;
            mem_addr_nxt = {addr[ADDR_W-1:2], 2'b00};
            if (!mem_read) begin
              mem_wr_nxt    = strobe;
              mem_wdata_nxt = repl;
            end
          end
        end
      end
      ACCESS: begin
        if (load_q) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          resp_store_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          rd_nxt         = load_extract(mem_rdata, f3_q, lo_q);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready_nxt = (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      cnt        <= '0;
      req_ready  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 4'b0000;
      resp_valid <= 1'b0;
      resp_store <= 1'b0;
      rd         <= '0;
    end else begin
      load_q     <= load_nxt;
      f3_q       <= f3_nxt;
      lo_q       <= lo_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_wr     <= mem_wr_nxt;
      resp_valid <= resp_valid_nxt;
      resp_store <= resp_store_nxt;
      rd         <= rd_nxt;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned <= 1'b0;
    else        misaligned <= misaligned_nxt;
  end
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: MEM_LAT=1 and MEM_LAT=3 instances share stimulus,
// each with its own word memory; a byte-level reference model predicts results.
module tb_lsu_mem_master;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [8:0]  addr = 9'h000;
  logic [31:0] wd = 32'h0;

  logic        req_ready1, resp_valid1, resp_store1, req_ready3, resp_valid3, resp_store3;
  logic [8:0]  mem_addr1, mem_addr3;
  logic [31:0] mem_wdata1, mem_rdata1, rd1, mem_wdata3, mem_rdata3, rd3;
  logic [3:0]  mem_wr1, mem_wr3;
`ifdef LSU_MISALIGN_EXC_EN
  logic        mis1, mis3;
`endif

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr), .wd(wd),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .mem_rdata(mem_rdata1),
    .resp_valid(resp_valid1), .resp_store(resp_store1), .rd(rd1)
`ifdef LSU_MISALIGN_EXC_EN
    , .misaligned(mis1)
`endif
  );

  lsu_mem_master #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr), .wd(wd),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3),
    .resp_valid(resp_valid3), .resp_store(resp_store3), .rd(rd3)
`ifdef LSU_MISALIGN_EXC_EN
    , .misaligned(mis3)
`endif
  );

  // Environment memories: read data is delayed MEM_LAT cycles after the address.
  logic [31:0] mem1 [128];
  logic [31:0] mem3 [128];
  logic [31:0] ref_mem [128];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  logic        init_mem = 1'b0, pre_en = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [31:0] pre_val = 32'h0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) begin
        mem1[i] <= init_word(i);
        mem3[i] <= init_word(i);
      end
    end else if (pre_en) begin
      mem1[pre_idx] <= pre_val;
      mem3[pre_idx] <= pre_val;
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_wr1[i]) mem1[mem_addr1[8:2]][8*i +: 8] <= mem_wdata1[8*i +: 8];
      if (mem_wr3[i]) mem3[mem_addr3[8:2]][8*i +: 8] <= mem_wdata3[8*i +: 8];
    end
    pipe1    <= mem1[mem_addr1[8:2]];
    pipe3[0] <= mem3[mem_addr3[8:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3[2];

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: byte-lane arithmetic on whole words.
  function automatic int model_size(input logic ld, input logic [2:0] f3);
    if (ld) return (f3 == 3'd0 || f3 == 3'd4) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2;
    return (f3 == 3'd0) ? 0 : (f3 == 3'd1) ? 1 : 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int a, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input int a, input int sz,
                                              input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2) return d;
    sh   = (sz == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic run_req(input logic rdf, input logic wrf, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d, input string tag,
                         output logic [31:0] o_rd1, output logic [31:0] o_rd3,
                         output logic [3:0] o_strb, output logic [31:0] o_wdata);
    logic        acc, ld, mis;
    int          sz, lat1, lat3, got1, got3, n1, n3, bad_ready, bad_wr;
    logic [31:0] exp_rd, exp_wdata;
    logic [3:0]  exp_strb;
    acc = rdf | wrf;
    ld  = rdf;
    sz  = model_size(ld, f3);
    mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    mis = acc && (((sz == 1) && (a % 2 != 0)) || ((sz == 2) && (a % 4 != 0)));
`endif
    lat1 = !acc ? 0 : mis ? 1 : ld ? 3 : 2;
    lat3 = !acc ? 0 : mis ? 1 : ld ? 5 : 2;
    exp_rd    = mis ? 32'h0 : model_load(ref_mem[a / 4], int'(a), f3);
    exp_strb  = (sz == 0) ? 4'(1 << (a % 4)) : (sz == 1) ? 4'(3 << (2 * ((a / 2) % 2))) : 4'hF;
    exp_wdata = (sz == 0) ? (d & 32'hFF) * 32'h01010101 :
                (sz == 1) ? (d & 32'hFFFF) * 32'h00010001 : d;
    o_rd1 = 32'h0; o_rd3 = 32'h0; o_strb = 4'h0; o_wdata = 32'h0;
    got1 = 0; got3 = 0; n1 = 0; n3 = 0; bad_ready = 0; bad_wr = 0;

    @(negedge clk);
    req_valid = 1'b1; mem_read = rdf; mem_write = wrf; funct3 = f3; addr = a; wd = d;
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    funct3 = 3'($urandom); addr = 9'($urandom); wd = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1 && acc && !mis) begin
        chk({tag, "_maddr1"}, 32'(mem_addr1), 32'((a / 4) * 4));
        chk({tag, "_maddr3"}, 32'(mem_addr3), 32'((a / 4) * 4));
        chk({tag, "_strb1"}, 32'(mem_wr1), ld ? 32'h0 : 32'(exp_strb));
        chk({tag, "_strb3"}, 32'(mem_wr3), ld ? 32'h0 : 32'(exp_strb));
        if (!ld) chk({tag, "_wdata"}, mem_wdata1, exp_wdata);
        o_strb  = mem_wr1;
        o_wdata = mem_wdata1;
      end else if (mem_wr1 != 4'h0 || mem_wr3 != 4'h0) begin
        bad_wr++;
      end
      if (req_ready1 !== (k > lat1)) bad_ready++;
      if (req_ready3 !== (k > lat3)) bad_ready++;
      if (resp_valid1) begin
        n1++;
        if (got1 == 0) begin
          got1 = k; o_rd1 = rd1;
          chk({tag, "_store1"}, 32'(resp_store1), 32'(!ld));
          if (ld || mis) chk({tag, "_rd1"}, rd1, exp_rd);
`ifdef LSU_MISALIGN_EXC_EN
          chk({tag, "_mis1"}, 32'(mis1), 32'(mis));
`endif
        end
      end
      if (resp_valid3) begin
        n3++;
        if (got3 == 0) begin
          got3 = k; o_rd3 = rd3;
          chk({tag, "_store3"}, 32'(resp_store3), 32'(!ld));
          if (ld || mis) chk({tag, "_rd3"}, rd3, exp_rd);
`ifdef LSU_MISALIGN_EXC_EN
          chk({tag, "_mis3"}, 32'(mis3), 32'(mis));
`endif
        end
      end
    end
    chk({tag, "_lat1"}, 32'(got1), 32'(lat1));
    chk({tag, "_lat3"}, 32'(got3), 32'(lat3));
    chk({tag, "_npulse"}, 32'(n1 + n3), acc ? 32'd2 : 32'd0);
    chk({tag, "_ready_pattern_errs"}, 32'(bad_ready), 32'd0);
    chk({tag, "_stray_strobe_cycles"}, 32'(bad_wr), 32'd0);
    if (acc && !ld && !mis) ref_mem[a / 4] = model_merge(ref_mem[a / 4], int'(a), sz, d);
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = idx; pre_val = val; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  typedef struct {
    string       name;
    logic        rdf, wrf;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] d;
    logic        pre;
    logic [31:0] pre_word;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } vec_t;

  function automatic vec_t mk(input string n, input logic r, input logic w, input logic [2:0] f,
                              input logic [8:0] a, input logic [31:0] d, input logic p,
                              input logic [31:0] pw, input logic [3:0] s, input logic [31:0] wdt,
                              input logic [31:0] rv);
    vec_t v;
    v.name = n; v.rdf = r; v.wrf = w; v.f3 = f; v.a = a; v.d = d; v.pre = p;
    v.pre_word = pw; v.strb = s; v.wdata = wdt; v.rdv = rv;
    return v;
  endfunction

  initial begin
    vec_t        vq[$];
    logic [31:0] o1, o3, ow;
    logic [3:0]  os;
    int          cnt_a, cnt_b;

    vq.push_back(mk("sw",      0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, 4'hF, 32'hDEADBEEF, 0));
    vq.push_back(mk("sb",      0, 1, 3'b000, 9'h013, 32'h000000A5, 0, 0, 4'h8, 32'hA5A5A5A5, 0));
    vq.push_back(mk("sh",      0, 1, 3'b001, 9'h012, 32'h00001234, 0, 0, 4'hC, 32'h12341234, 0));
    vq.push_back(mk("lb",      1, 0, 3'b000, 9'h011, 0, 1, 32'h12348056, 0, 0, 32'hFFFFFF80));
    vq.push_back(mk("lbu",     1, 0, 3'b100, 9'h011, 0, 0, 0, 0, 0, 32'h00000080));
    vq.push_back(mk("lh",      1, 0, 3'b001, 9'h012, 0, 1, 32'h80011111, 0, 0, 32'hFFFF8001));
    vq.push_back(mk("lhu",     1, 0, 3'b101, 9'h012, 0, 0, 0, 0, 0, 32'h00008001));
    vq.push_back(mk("lw",      1, 0, 3'b010, 9'h004, 0, 1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D));
`ifdef LSU_MISALIGN_EXC_EN
    vq.push_back(mk("lw_mis",  1, 0, 3'b010, 9'h006, 0, 1, 32'h13572468, 0, 0, 32'h00000000));
`else
    vq.push_back(mk("lw_mis",  1, 0, 3'b010, 9'h006, 0, 1, 32'h13572468, 0, 0, 32'h13572468));
`endif
    vq.push_back(mk("both_rw", 1, 1, 3'b010, 9'h020, 32'h55555555, 1, 32'h0BADF00D, 0, 0, 32'h0BADF00D));
    vq.push_back(mk("none",    0, 0, 3'b010, 9'h024, 32'h77777777, 0, 0, 0, 0, 0));

    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    init_mem = 1'b1;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    chk("rst_ready1", 32'(req_ready1), 32'd1);
    chk("rst_ready3", 32'(req_ready3), 32'd1);
    chk("rst_resp", 32'({resp_valid1, resp_store1, resp_valid3, resp_store3}), 32'd0);
    chk("rst_mem_wr", 32'({mem_wr1, mem_wr3}), 32'd0);
    chk("rst_mem_addr", 32'({mem_addr1, mem_addr3}), 32'd0);
    chk("rst_wdata_rd", mem_wdata1 | rd1 | mem_wdata3 | rd3, 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      if (vq[i].pre) preload(7'(vq[i].a / 4), vq[i].pre_word);
      run_req(vq[i].rdf, vq[i].wrf, vq[i].f3, vq[i].a, vq[i].d, vq[i].name, o1, o3, os, ow);
      if (vq[i].rdf) begin
        chk({vq[i].name, "_tbl_rd1"}, o1, vq[i].rdv);
        chk({vq[i].name, "_tbl_rd3"}, o3, vq[i].rdv);
      end else if (vq[i].wrf) begin
        chk({vq[i].name, "_tbl_strb"}, 32'(os), 32'(vq[i].strb));
        chk({vq[i].name, "_tbl_wdata"}, ow, vq[i].wdata);
      end
    end

    // Back-to-back stores with req_valid held: one issue every 3 cycles.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
    addr = 9'h0C0; wd = 32'h600DCAFE;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 9) req_valid = 1'b0;
      if (mem_wr1 == 4'hF) cnt_a++;
      if (resp_valid1) cnt_b++;
    end
    ref_mem[9'h0C0 / 4] = 32'h600DCAFE;
    chk("b2b_strobes", 32'(cnt_a), 32'd3);
    chk("b2b_resps", 32'(cnt_b), 32'd3);
    repeat (4) @(negedge clk);

    // Reset during a load's WAIT: outputs clear at once, no response follows.
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 9'h040;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wait_rst_ready", 32'({req_ready1, req_ready3}), 32'h3);
    chk("wait_rst_maddr", 32'({mem_addr1, mem_addr3}), 32'd0);
    chk("wait_rst_rd", rd1 | rd3, 32'd0);
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (resp_valid1 || resp_valid3) cnt_a++;
    end
    chk("wait_rst_no_resp", 32'(cnt_a), 32'd0);
    run_req(1'b0, 1'b1, 3'b010, 9'h044, 32'h0F1E2D3C, "post_rst_sw", o1, o3, os, ow);

    // Reset while a store strobe is active: the strobe drops immediately.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
    addr = 9'h080; wd = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    chk("st_rst_before", 32'(mem_wr1), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("st_rst_after", 32'({mem_wr1, mem_wr3}), 32'd0);
    chk("st_rst_wdata", mem_wdata1 | mem_wdata3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      run_req(1'($urandom), 1'($urandom), 3'($urandom), 9'($urandom), $urandom, "rnd",
              o1, o3, os, ow);

    @(negedge clk);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 128; i++) begin
      if (mem1[i] !== ref_mem[i]) cnt_a++;
      if (mem3[i] !== ref_mem[i]) cnt_b++;
    end
    chk("mem1_image_bad_words", 32'(cnt_a), 32'd0);
    chk("mem3_image_bad_words", 32'(cnt_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the pipeline MEM stage and the word-organised data memory (32-bit words, 4-bit byte-write strobes, registered read data).
- Accepts one load or store per handshake and generates a word-aligned address, byte strobes and replicated store data.
- Waits a fixed read latency, then extracts and sign- or zero-extends load data.
- Stalls the pipeline through req_ready while an access is in flight.

Parameters:
- ADDR_W, 9: byte-address width seen by the memory.
- DATA_W, 32: data width; fixed at 32, other values unsupported.
- MEM_LAT, 1: cycles from mem_addr valid to mem_rdata valid; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the pipeline stalls while it is low.
- mem_read  in  1  load request; from the control unit.
- mem_write  in  1  store request; from the control unit.
- funct3  in  3  instruction bits 14:12.
- addr  in  ADDR_W  byte address; the ADDR_W LSBs of the ALU result.
- wd  in  DATA_W  store data from rs2.
- mem_addr  out  ADDR_W  word-aligned address; bits 1:0 always 0.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_wr  out  4  byte write strobes; bit i writes byte lane i.
- mem_rdata  in  DATA_W  memory read word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_store  out  1  high with resp_valid when the completed access was a store.
- rd  out  DATA_W  extended load data; valid with resp_valid.

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- Reset (asynchronous, immediate): state=IDLE; mem_wr=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_store=0, rd=0.
  - Reset mid-access aborts the access: any mem_wr strobe drops at once and no resp_valid is issued.
- Accept: in IDLE, a cycle T with req_valid=1 and (mem_read|mem_write)=1 latches funct3, addr and wd, and the state moves to ACCESS.
  - req_valid with neither mem_read nor mem_write is ignored; the block stays in IDLE.
  - If mem_read and mem_write are both 1, the read wins.
- ACCESS (cycle T+1): mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Store: mem_wr = strobe for exactly this cycle, then DONE.
  - Load: mem_wr = 0, then WAIT.
- WAIT: a down-counter loaded with MEM_LAT-1 holds mem_addr stable.
  - mem_rdata is sampled at cycle T+1+MEM_LAT; the state then moves to DONE.
- DONE: resp_valid=1 for one cycle, then IDLE, with req_ready=1 in the following cycle.
  - Store response: cycle T+2.
  - Load response: cycle T+2+MEM_LAT.
  - Minimum back-to-back store issue is one store every 3 cycles.
- Store encoding (funct3):
  - 000 SB: strobe 0001<<addr[1:0]; mem_wdata = {4{wd[7:0]}}.
  - 001 SH: strobe 0011<<{addr[1],1'b0}; mem_wdata = {2{wd[15:0]}}.
  - 010 SW: strobe 1111; mem_wdata = wd.
  - Any other value is treated as SW.
- Load extraction: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW and any other value: full word.
- Outside DONE: rd holds its last value and resp_valid/resp_store are 0.
- Address wrap: none needed; mem_addr is simply addr with bits 1:0 cleared.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: adds output port misaligned (1 bit, reset 0).
  - Misaligned means a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
  - A misaligned request skips ACCESS/WAIT and goes straight to DONE: no mem_wr, mem_addr unchanged, resp_valid at T+1, misaligned=1, rd=0.
  - misaligned is 0 on all other responses.
- Undefined: no port. Misaligned accesses are naturally aligned by ignoring the low bits: half uses addr[1] only, word uses addr[1:0]=0. Timing is the normal timing.

Test Plan:
- SW, addr=0x010, wd=0xDEADBEEF, MEM_LAT=1 -> at T+1: mem_addr=0x010, mem_wr=1111, mem_wdata=0xDEADBEEF; at T+2: resp_valid=1, resp_store=1; mem_wr=0 elsewhere.
- SB, addr=0x013, wd=0x000000A5 -> mem_wr=1000, mem_wdata=0xA5A5A5A5. SH, addr=0x012, wd=0x1234 -> mem_wr=1100, mem_wdata=0x12341234.
- LB, addr=0x011, mem word 0x12348056 -> rd=0xFFFFFF80 with resp_valid at T+2+MEM_LAT. LBU on the same word -> rd=0x00000080. Repeat with MEM_LAT=3: resp_valid at T+5.
- LH, addr=0x012, word 0x80011111 -> rd=0xFFFF8001. LHU -> rd=0x00008001. LW, addr=0x004 -> rd = full word; req_ready is low from T+1 through the response cycle.
- LW, addr=0x006. With the macro: no memory access, resp_valid at T+1, misaligned=1, rd=0. Without the macro: mem_addr=0x004 and normal response.
- Issue a load, then pull rst_n low during WAIT -> outputs reset immediately and no resp_valid occurs. After release, req_ready=1 and a new SW completes normally.
